// File: rtl/eth_header_parser_if.sv
// Stream and header handshake bundle between the RX FIFO, the header parser and the ACL lookup stage.
interface eth_header_parser_if;
  logic [31:0] i_rx_data;
  logic [3:0]  i_rx_tkeep;
  logic        i_rx_tvalid;
  logic        i_rx_tlast;
  logic        o_rx_tready;
  logic [47:0] o_dest_mac;
  logic [47:0] o_src_mac;
  logic [15:0] o_ether_type;
  logic        o_hdr_valid;
  logic        i_hdr_ready;

  modport slave (
    input  i_rx_data, i_rx_tkeep, i_rx_tvalid, i_rx_tlast, i_hdr_ready,
    output o_rx_tready, o_dest_mac, o_src_mac, o_ether_type, o_hdr_valid
  );

  modport master (
    output i_rx_data, i_rx_tkeep, i_rx_tvalid, i_rx_tlast, i_hdr_ready,
    input  o_rx_tready, o_dest_mac, o_src_mac, o_ether_type, o_hdr_valid
  );
endinterface

// File: rtl/eth_header_parser.sv
// Parses dest/src MAC and EtherType from a 32-bit big-endian frame stream, stalls until the
// header is accepted, then drains the payload and reports length, runt/giant and frame count.
module eth_header_parser #(
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned MAX_FRAME_BYTES = 1514,
  parameter int unsigned LEN_W           = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eth_header_parser_if.slave   bus,
  output logic                 o_frame_done,
  output logic [LEN_W-1:0]     o_frame_len,
  output logic                 o_err_runt,
  output logic                 o_err_giant,
  output logic [31:0]          o_frame_cnt
);

  localparam int unsigned HDR_BYTES = 14;

  typedef enum logic [1:0] {S_HDR, S_HDR_WAIT, S_PAYLOAD, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         widx_q, widx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [47:0]        dest_q, dest_d, src_q, src_d;
  logic [15:0]        type_q, type_d;
  logic               hdr_last_q, hdr_last_d;
  logic               tready_q, tready_d;
  logic               hdr_valid_q, hdr_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [LEN_W-1:0]   frame_len_q, frame_len_d;
  logic               err_runt_q, err_runt_d;
  logic               err_giant_q, err_giant_d;
  logic [31:0]        frame_cnt_q, frame_cnt_d;

  logic               beat_c;
  logic               hdr_inc_c;
  logic [2:0]         beat_bytes_c;
  logic [LEN_W:0]     len_sum_c;
  logic [LEN_W-1:0]   len_sat_c;

  // Bytes contributed by the current beat; unlisted tkeep patterns count as a full word.
  always_comb begin
    beat_bytes_c = 3'd4;
    if (bus.i_rx_tlast) begin
      case (bus.i_rx_tkeep)
        4'b1111: beat_bytes_c = 3'd4;
        4'b1110: beat_bytes_c = 3'd3;
        4'b1100: beat_bytes_c = 3'd2;
        4'b1000: beat_bytes_c = 3'd1;
        4'b0000: beat_bytes_c = 3'd0;
        default: beat_bytes_c = 3'd4;
      endcase
    end
    len_sum_c = {1'b0, len_q} + (LEN_W+1)'(beat_bytes_c);
    len_sat_c = len_sum_c[LEN_W] ? {LEN_W{1'b1}} : len_sum_c[LEN_W-1:0];
  end

  assign beat_c = bus.i_rx_tvalid & tready_q;

  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    len_d        = len_q;
    dest_d       = dest_q;
    src_d        = src_q;
    type_d       = type_q;
    hdr_last_d   = hdr_last_q;
    hdr_inc_c    = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    err_runt_d   = err_runt_q;
    err_giant_d  = err_giant_q;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      S_HDR: begin
        if (beat_c) begin
          len_d = len_sat_c;
          case (widx_q)
            2'd0: dest_d[47:16] = bus.i_rx_data;
            2'd1: begin
              dest_d[15:0]  = bus.i_rx_data[31:16];
              src_d[47:32]  = bus.i_rx_data[15:0];
            end
            2'd2: src_d[31:0] = bus.i_rx_data;
            default: type_d = bus.i_rx_data[31:16];
          endcase
          if (widx_q == 2'd3 && len_sat_c >= LEN_W'(HDR_BYTES)) begin
            state_d    = S_HDR_WAIT;
            hdr_last_d = bus.i_rx_tlast;
          end else if (bus.i_rx_tlast) begin
            state_d   = S_DONE;
            hdr_inc_c = 1'b1;
          end else begin
            widx_d = widx_q + 2'd1;
          end
        end
      end
      S_HDR_WAIT: begin
        if (bus.i_hdr_ready) begin
          state_d = hdr_last_q ? S_DONE : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (beat_c) begin
          len_d = len_sat_c;
          if (bus.i_rx_tlast) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d    = S_HDR;
        widx_d     = 2'd0;
        len_d      = '0;
        hdr_last_d = 1'b0;
      end
    endcase

    tready_d    = (state_d == S_HDR) || (state_d == S_PAYLOAD);
    hdr_valid_d = (state_d == S_HDR_WAIT);

    // Frame status is launched on entry to S_DONE so it lands one cycle after tlast.
    if (state_d == S_DONE && state_q != S_DONE) begin
      frame_done_d = 1'b1;
      frame_len_d  = len_d;
      err_runt_d   = (32'(len_d) < MIN_FRAME_BYTES) || hdr_inc_c;
      err_giant_d  = (32'(len_d) > MAX_FRAME_BYTES);
      frame_cnt_d  = frame_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR;
      widx_q       <= 2'd0;
      len_q        <= '0;
      dest_q       <= '0;
      src_q        <= '0;
      type_q       <= '0;
      hdr_last_q   <= 1'b0;
      tready_q     <= 1'b0;
      hdr_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      err_runt_q   <= 1'b0;
      err_giant_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      len_q        <= len_d;
      dest_q       <= dest_d;
      src_q        <= src_d;
      type_q       <= type_d;
      hdr_last_q   <= hdr_last_d;
      tready_q     <= tready_d;
      hdr_valid_q  <= hdr_valid_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      err_runt_q   <= err_runt_d;
      err_giant_q  <= err_giant_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.o_rx_tready  = tready_q;
  assign bus.o_dest_mac   = dest_q;
  assign bus.o_src_mac    = src_q;
  assign bus.o_ether_type = type_q;
  assign bus.o_hdr_valid  = hdr_valid_q;
  assign o_frame_done     = frame_done_q;
  assign o_frame_len      = frame_len_q;
  assign o_err_runt       = err_runt_q;
  assign o_err_giant      = err_giant_q;
  assign o_frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_eth_header_parser.sv
// Directed bench for eth_header_parser: header extraction, stall, runt/giant, saturation, reset.
module tb_eth_header_parser;

  localparam int unsigned LEN_W = 11;

  logic              clk;
  logic              rst_n;
  logic              frame_done;
  logic [LEN_W-1:0]  frame_len;
  logic              err_runt;
  logic              err_giant;
  logic [31:0]       frame_cnt;

  eth_header_parser_if bus ();

  eth_header_parser #(
    .MIN_FRAME_BYTES(60),
    .MAX_FRAME_BYTES(1514),
    .LEN_W(LEN_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .o_frame_done (frame_done),
    .o_frame_len  (frame_len),
    .o_err_runt   (err_runt),
    .o_err_giant  (err_giant),
    .o_frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hv_cnt   = 0;

  logic [47:0] dest;
  logic [47:0] src;
  logic [15:0] etype;

  // Number of cycles o_hdr_valid is seen high, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.o_hdr_valid) hv_cnt <= hv_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    case (i)
      0:       return dest[47:16];
      1:       return {dest[15:0], src[47:32]};
      2:       return src[31:0];
      3:       return {etype, 16'h4500};
      default: return 32'hD000_0000 | 32'(i);
    endcase
  endfunction

  // Present one word from a negedge and return at the negedge after it is accepted.
  task automatic send_word(input logic [31:0] data, input logic last, input logic [3:0] keep);
    int  n = 0;
    logic ok;
    bus.i_rx_tvalid = 1'b1;
    bus.i_rx_data   = data;
    bus.i_rx_tlast  = last;
    bus.i_rx_tkeep  = keep;
    do begin
      ok = bus.o_rx_tready;
      @(negedge clk);
      n++;
    end while (!ok && n < 200);
    if (!ok) check_eq("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic check_header(input string tag);
    check_eq({tag, "_hv"},   64'(bus.o_hdr_valid),  64'd1);
    check_eq({tag, "_dest"}, 64'(bus.o_dest_mac),   64'(dest));
    check_eq({tag, "_src"},  64'(bus.o_src_mac),    64'(src));
    check_eq({tag, "_type"}, 64'(bus.o_ether_type), 64'(etype));
  endtask

  task automatic run_frame(input string tag, input int nwords, input logic [3:0] last_keep,
                           input int stall, input bit exp_hdr, input int exp_len,
                           input bit exp_runt, input bit exp_giant, input int exp_cnt);
    int hv0;
    logic last;
    hv0 = hv_cnt;
    if (stall > 0) bus.i_hdr_ready = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      last = (i == nwords - 1);
      send_word(word_at(i), last, last ? last_keep : 4'hF);
      if (i == 3 && exp_hdr) begin
        check_header(tag);
        for (int s = 0; s < stall; s++) begin
          check_eq({tag, "_stall_trdy"}, 64'(bus.o_rx_tready), 64'd0);
          check_header({tag, "_stall"});
          @(negedge clk);
        end
        bus.i_hdr_ready = 1'b1;
      end
    end
    bus.i_rx_tvalid = 1'b0;
    bus.i_rx_tlast  = 1'b0;
    if (nwords == 4 && exp_hdr) @(negedge clk);
    check_eq({tag, "_done"},  64'(frame_done), 64'd1);
    check_eq({tag, "_len"},   64'(frame_len),  64'(exp_len));
    check_eq({tag, "_runt"},  64'(err_runt),   64'(exp_runt));
    check_eq({tag, "_giant"}, 64'(err_giant),  64'(exp_giant));
    check_eq({tag, "_cnt"},   64'(frame_cnt),  64'(exp_cnt));
    check_eq({tag, "_bubble"}, 64'(bus.o_rx_tready), 64'd0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 64'(frame_done), 64'd0);
    check_eq({tag, "_len_hold"}, 64'(frame_len), 64'(exp_len));
    check_eq({tag, "_hv_cycles"}, 64'(hv_cnt - hv0), exp_hdr ? 64'(stall + 1) : 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_trdy"},  64'(bus.o_rx_tready),  64'd0);
    check_eq({tag, "_hv"},    64'(bus.o_hdr_valid),  64'd0);
    check_eq({tag, "_dest"},  64'(bus.o_dest_mac),   64'd0);
    check_eq({tag, "_src"},   64'(bus.o_src_mac),    64'd0);
    check_eq({tag, "_type"},  64'(bus.o_ether_type), 64'd0);
    check_eq({tag, "_done"},  64'(frame_done),       64'd0);
    check_eq({tag, "_len"},   64'(frame_len),        64'd0);
    check_eq({tag, "_runt"},  64'(err_runt),         64'd0);
    check_eq({tag, "_giant"}, 64'(err_giant),        64'd0);
    check_eq({tag, "_cnt"},   64'(frame_cnt),        64'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.i_rx_data   = '0;
    bus.i_rx_tkeep  = '0;
    bus.i_rx_tvalid = 1'b0;
    bus.i_rx_tlast  = 1'b0;
    bus.i_hdr_ready = 1'b1;
    dest  = 48'h0014_2201_2345;
    src   = 48'h0014_2267_89AB;
    etype = 16'h0800;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 378 full words + 2 bytes = 1514
    run_frame("f1514",   379, 4'b1100, 0, 1'b1, 1514, 1'b0, 1'b0, 1);
    run_frame("stall",   379, 4'b1100, 5, 1'b1, 1514, 1'b0, 1'b0, 2);
    dest  = 48'hFFFF_FFFF_FFFF;
    src   = 48'h0200_0000_0001;
    etype = 16'h0806;
    run_frame("w2last",    3, 4'b1111, 0, 1'b0,   12, 1'b1, 1'b0, 3);
    run_frame("f40",      10, 4'b1111, 0, 1'b1,   40, 1'b1, 1'b0, 4);
    run_frame("w3short",   4, 4'b1000, 0, 1'b0,   13, 1'b1, 1'b0, 5);
    run_frame("hdronly",   4, 4'b1100, 0, 1'b1,   14, 1'b1, 1'b0, 6);
    run_frame("f60",      15, 4'b1111, 0, 1'b1,   60, 1'b0, 1'b0, 7);
    run_frame("f1515",   379, 4'b1110, 0, 1'b1, 1515, 1'b0, 1'b1, 8);
    run_frame("f1600",   400, 4'b1111, 0, 1'b1, 1600, 1'b0, 1'b1, 9);
    run_frame("sat",     600, 4'b1111, 0, 1'b1, 2047, 1'b0, 1'b1, 10);

    // Frame A cut by reset in the middle of its payload
    for (int i = 0; i < 8; i++) send_word(word_at(i), 1'b0, 4'hF);
    bus.i_rx_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    dest  = 48'h0A0B_0C0D_0E0F;
    src   = 48'h1122_3344_5566;
    etype = 16'h86DD;
    run_frame("after_rst", 16, 4'b1111, 0, 1'b1, 64, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_header_parser.md
Name: eth_header_parser

Overview:
- Sits directly downstream of the RX FIFO. Consumes the 32-bit big-endian Ethernet word stream it produces.
- Extracts destination MAC, source MAC and EtherType, and presents them to the ACL lookup stage with a valid/ready handshake.
- Stalls the stream until the lookup accepts the header, then drains the payload.
- Reports frame length, runt/giant errors and a frame count.

Parameters:
- MIN_FRAME_BYTES, 60, minimum legal length in bytes, excluding FCS.
- MAX_FRAME_BYTES, 1514, maximum legal length in bytes, excluding FCS.
- LEN_W, 11, width of the byte-length counter. Saturates at 2^LEN_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_rx_data  in  32  frame word; byte 0 in [31:24]
- i_rx_tkeep  in  4  byte enables, MSB-first; honoured only on tlast beat
- i_rx_tvalid  in  1  word valid
- i_rx_tlast  in  1  last word of frame
- o_rx_tready  out  1  word accepted when tvalid&tready
- o_dest_mac  out  48  extracted destination MAC
- o_src_mac  out  48  extracted source MAC
- o_ether_type  out  16  extracted EtherType
- o_hdr_valid  out  1  header fields valid
- i_hdr_ready  in  1  ACL stage accepts header
- o_frame_done  out  1  one-cycle pulse at end of frame
- o_frame_len  out  LEN_W  bytes in frame; valid with o_frame_done
- o_err_runt  out  1  length < MIN_FRAME_BYTES or header incomplete; valid with o_frame_done
- o_err_giant  out  1  length > MAX_FRAME_BYTES; valid with o_frame_done
- o_frame_cnt  out  32  completed frames, wraps at 2^32

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0.
  - State S_HDR, word index 0, length 0.
- Beat acceptance: a beat is accepted only when i_rx_tvalid & o_rx_tready.
- o_rx_tready:
  - 1 in S_HDR and S_PAYLOAD.
  - 0 in S_HDR_WAIT and S_DONE.
- Word mapping, by index of accepted word in the frame:
  - w0 = dest[47:16]
  - w1 = {dest[15:0], src[47:32]}
  - w2 = src[31:0]
  - w3[31:16] = ether_type
- Header fields are registered as words arrive. They hold stable from o_hdr_valid assertion until the next frame's w0.
- Length per beat:
  - Non-last beat adds 4.
  - tlast beat adds count of tkeep: 1111=4, 1110=3, 1100=2, 1000=1, 0000=0.
  - Any other tkeep pattern is counted as 4.
  - Counter saturates at 2^LEN_W-1 and does not wrap.
- S_HDR:
  - Accept w0..w3.
  - On w3 accepted, if bytes >= 14 go to S_HDR_WAIT; o_hdr_valid is 1 the next cycle.
  - tlast before header complete (any of w0..w2, or w3 with tkeep yielding < 14 bytes) goes to S_DONE with runt=1. o_hdr_valid is never asserted for that frame.
- S_HDR_WAIT:
  - o_hdr_valid=1, tready=0.
  - On i_hdr_ready, drop o_hdr_valid the next cycle.
  - Go to S_DONE if w3 was tlast, else go to S_PAYLOAD.
  - Zero upstream words are consumed while waiting.
- S_PAYLOAD: accept words; on tlast accepted go to S_DONE.
- S_DONE (one cycle):
  - o_frame_done=1.
  - o_frame_len holds the final length.
  - o_err_runt = (len < MIN) or header incomplete.
  - o_err_giant = (len > MAX), using the saturated value.
  - o_frame_cnt increments.
  - Next state S_HDR; word index and length cleared.
- Latency:
  - hdr_valid appears 1 cycle after w3 is accepted.
  - frame_done appears 1 cycle after tlast is accepted.
  - One bubble cycle per frame (S_DONE).
- o_frame_len, o_err_runt and o_err_giant hold until the next o_frame_done. Only the o_frame_done pulse qualifies them.
- Simultaneous w3 and tlast: header handshake completes first, then S_DONE.
- tvalid deasserted mid-frame: state and counters hold; no timeout.
- Reset mid-frame: partial frame discarded, no frame_done, counters cleared. The next w0 after release parses normally.

Test Plan:
1. 1514-byte frame, dest 0x001422012345, src 0x0014226789AB, type 0x0800, last tkeep=1100, i_hdr_ready=1 -> o_hdr_valid 1 cycle after w3 with exact fields; frame_done with len=1514, runt=0, giant=0; frame_cnt=1.
2. Same frame with i_hdr_ready held 0 for 5 cycles after hdr_valid -> tready=0 for those cycles; fields stable; all 379 words consumed in order; len=1514.
3. 3-word frame (tlast on w2, tkeep=1111) -> no hdr_valid; frame_done with len=12, runt=1.
4. 40-byte frame (10 words) -> hdr_valid asserted; frame_done with len=40, runt=1, giant=0.
5. 1600-byte frame -> len=1600, giant=1. 600-word frame with LEN_W=11 -> len saturates at 2047, giant=1.
6. rst_n pulsed low during payload of frame A, then a full 64-byte frame B -> all outputs 0 during reset; B gives correct header, len=64, frame_cnt=1.
